biquad_bank: RTL and testbench

- Parametrised, multi-channel, time-multiplexed direct-form-I biquad IIR filter with a runtime-writable bank of coefficient sets.
- Sits in the channel-strip audio path at the sample rate; one instance serves lowpass, highpass or any other biquad, per the loaded coefficients.
- Accepts one frame of NCH samples per handshake and shares a single multiplier across all taps and channels.
- Adds valid/ready flow control, saturated feedback, glitch-free coefficient switching, per-channel clip flags and history flush.

---
 rtl/biquad_bank.sv | 258 +++++++++++++++++++++++++
 tb/tb_biquad_bank.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_bank.sv
// biquad_bank: time-multiplexed, multi-channel direct-form-I biquad IIR filter
// with a runtime-writable bank of NSET coefficient sets and one shared multiplier.
//
// Ports:
//   clk_144, reset_n            clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   input frame handshake, NCH packed W-bit samples
//   sel                         coefficient set for the frame, sampled on accept
//   out_valid/out_ready         output frame handshake
//   out_data/out_sat            filtered samples and per-channel clip flags
//   coef_we/coef_set/coef_idx/coef_data  bank write port (0=b0,1=b1,2=b2,3=a1,4=a2)
//   flush                       clear history and abort the frame in flight
//   busy                        high while multiplying or writing back
module biquad_bank #(
  parameter int unsigned W               = 16,
  parameter int unsigned CW              = 32,
  parameter int unsigned FRAC            = 30,
  parameter int unsigned NCH             = 2,
  parameter int unsigned NSET            = 8,
  parameter bit          CLEAR_ON_SWITCH = 1'b1
) (
  input  logic                     clk_144,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NCH*W-1:0]         in_data,
  input  logic [$clog2(NSET)-1:0]  sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NCH*W-1:0]         out_data,
  output logic [NCH-1:0]           out_sat,
  input  logic                     coef_we,
  input  logic [$clog2(NSET)-1:0]  coef_set,
  input  logic [2:0]               coef_idx,
  input  logic [CW-1:0]            coef_data,
  input  logic                     flush,
  output logic                     busy
);

  localparam int unsigned ACCW = W + CW + 3;
  localparam int unsigned SW   = $clog2(NSET);
  localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned NTAP = 5;

  localparam logic signed [CW-1:0]   COEF_ONE = CW'(1) << FRAC;
  localparam logic signed [ACCW-1:0] SAT_MAX  = ACCW'((1 << (W - 1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             tap_q, tap_d;
  logic [CHW-1:0]         ch_q, ch_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic [NCH*W-1:0]       out_data_q;
  logic [NCH-1:0]         out_sat_q;

  logic signed [CW-1:0]   coef_q   [NSET][NTAP];
  logic signed [CW-1:0]   shadow_q [NTAP];
  logic signed [W-1:0]    x0_q [NCH];
  logic signed [W-1:0]    x1_q [NCH];
  logic signed [W-1:0]    x2_q [NCH];
  logic signed [W-1:0]    y1_q [NCH];
  logic signed [W-1:0]    y2_q [NCH];
  logic [SW-1:0]          prev_set_q;
  logic signed [ACCW-1:0] acc_q;

  logic [SW-1:0]          sel_eff_c;
  logic                   accept_c;
  logic                   clear_c;
  logic                   coef_wr_c;
  logic signed [W-1:0]    opnd_c;
  logic signed [CW-1:0]   tap_coef_c;
  logic signed [ACCW-1:0] prod_c;
  logic signed [ACCW-1:0] shift_c;
  logic signed [W-1:0]    sat_y_c;
  logic                   clip_c;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign busy      = busy_q;

  // Out-of-range set selects fall back to set 0.
  assign sel_eff_c = (32'(sel) < NSET) ? sel : '0;
  assign accept_c  = (state_q == S_IDLE) && in_valid && in_ready_q && !flush;
  assign clear_c   = CLEAR_ON_SWITCH && (sel_eff_c != prev_set_q);
  assign coef_wr_c = coef_we && (coef_idx < 3'd5) && (32'(coef_set) < NSET);

  // Tap operand/coefficient select for the shared multiplier.
  always_comb begin
    opnd_c     = x0_q[ch_q];
    tap_coef_c = shadow_q[0];
    case (tap_q)
      3'd0: begin opnd_c = x0_q[ch_q]; tap_coef_c = shadow_q[0]; end
      3'd1: begin opnd_c = x1_q[ch_q]; tap_coef_c = shadow_q[1]; end
      3'd2: begin opnd_c = x2_q[ch_q]; tap_coef_c = shadow_q[2]; end
      3'd3: begin opnd_c = y1_q[ch_q]; tap_coef_c = shadow_q[3]; end
      default: begin opnd_c = y2_q[ch_q]; tap_coef_c = shadow_q[4]; end
    endcase
  end

  assign prod_c  = ACCW'(opnd_c) * ACCW'(tap_coef_c);
  assign shift_c = acc_q >>> FRAC;

  // Saturate the scaled sum to the W-bit sample range.
  always_comb begin
    sat_y_c = shift_c[W-1:0];
    clip_c  = 1'b0;
    if (shift_c > SAT_MAX) begin
      sat_y_c = SAT_MAX[W-1:0];
      clip_c  = 1'b1;
    end else if (shift_c < SAT_MIN) begin
      sat_y_c = SAT_MIN[W-1:0];
      clip_c  = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      ch_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      ch_q        <= ch_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // FSM next state and registered handshake/status outputs.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    ch_d    = ch_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = S_MAC;
          tap_d   = '0;
          ch_d    = '0;
        end
      end
      S_MAC: begin
        if (tap_q == 3'd4) begin
          tap_d   = '0;
          state_d = S_WB;
        end else begin
          tap_d = tap_q + 3'd1;
        end
      end
      S_WB: begin
        if (ch_q == CHW'(NCH - 1)) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + CHW'(1);
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // flush overrides everything, including an accept in the same cycle.
    if (flush) begin
      state_d = S_IDLE;
      tap_d   = '0;
      ch_d    = '0;
    end
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_MAC) || (state_d == S_WB);
  end

  // Coefficient bank; resets to passthrough in every set.
  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < int'(NSET); s++) begin
        for (int t = 0; t < int'(NTAP); t++) begin
          coef_q[s][t] <= (t == 0) ? COEF_ONE : '0;
        end
      end
    end else if (coef_wr_c) begin
      coef_q[coef_set][coef_idx] <= coef_data;
    end
  end

  // Frame shadow copy, sample latch and per-channel history.
  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      for (int t = 0; t < int'(NTAP); t++) shadow_q[t] <= '0;
      for (int c = 0; c < int'(NCH); c++) begin
        x0_q[c] <= '0;
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        y1_q[c] <= '0;
        y2_q[c] <= '0;
      end
      prev_set_q <= '0;
    end else if (flush) begin
      for (int c = 0; c < int'(NCH); c++) begin
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        y1_q[c] <= '0;
        y2_q[c] <= '0;
      end
      prev_set_q <= '0;
    end else if (accept_c) begin
      for (int t = 0; t < int'(NTAP); t++) shadow_q[t] <= coef_q[sel_eff_c][t];
      for (int c = 0; c < int'(NCH); c++) begin
        x0_q[c] <= in_data[c*W +: W];
        if (clear_c) begin
          x1_q[c] <= '0;
          x2_q[c] <= '0;
          y1_q[c] <= '0;
          y2_q[c] <= '0;
        end
      end
      prev_set_q <= sel_eff_c;
    end else if (state_q == S_WB) begin
      x2_q[ch_q] <= x1_q[ch_q];
      x1_q[ch_q] <= x0_q[ch_q];
      y2_q[ch_q] <= y1_q[ch_q];
      y1_q[ch_q] <= sat_y_c;
    end
  end

  // Accumulator: restarts with the tap-0 product of each channel.
  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (state_q == S_MAC) begin
      acc_q <= (tap_q == 3'd0) ? prod_c : acc_q + prod_c;
    end
  end

  // Output sample and clip flag per channel, held through DONE.
  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q <= '0;
      out_sat_q  <= '0;
    end else if ((state_q == S_WB) && !flush) begin
      out_data_q[ch_q*W +: W] <= sat_y_c;
      out_sat_q[ch_q]         <= clip_c;
    end
  end

endmodule

// File: tb/tb_biquad_bank.sv
// Directed testbench for biquad_bank (default parameters: W=16, CW=32, FRAC=30, NCH=2, NSET=8).
module tb_biquad_bank;

  logic        clk_144 = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_sat;
  logic        coef_we;
  logic [2:0]  coef_set;
  logic [2:0]  coef_idx;
  logic [31:0] coef_data;
  logic        flush;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t_acc  = 0;

  always #5 clk_144 = ~clk_144;
  always @(posedge clk_144) cyc <= cyc + 1;

  biquad_bank dut (
    .clk_144  (clk_144),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .sel      (sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .coef_we  (coef_we),
    .coef_set (coef_set),
    .coef_idx (coef_idx),
    .coef_data(coef_data),
    .flush    (flush),
    .busy     (busy)
  );

  // All stimulus tasks start and end just after a falling edge.
  task automatic coef_write(input logic [2:0] s, input logic [2:0] idx, input logic [31:0] v);
    coef_we   = 1'b1;
    coef_set  = s;
    coef_idx  = idx;
    coef_data = v;
    @(negedge clk_144);
    coef_we = 1'b0;
  endtask

  task automatic start_frame(input logic [2:0] s, input logic signed [15:0] a, input logic signed [15:0] b);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk_144);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got %0b want 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = {b, a};
    sel      = s;
    t_acc    = cyc;
    @(negedge clk_144);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget, output int lat, output bit seen);
    while (!out_valid && (cyc - t_acc) < budget) @(negedge clk_144);
    seen = out_valid;
    lat  = cyc - t_acc;
  endtask

  task automatic take_out;
    out_ready = 1'b1;
    @(negedge clk_144);
    out_ready = 1'b0;
  endtask

  task automatic run_frame(input logic [2:0] s, input logic signed [15:0] a, input logic signed [15:0] b,
                           output logic signed [15:0] y0, output logic signed [15:0] y1,
                           output logic [1:0] st, output int lat, output bit seen);
    start_frame(s, a, b);
    wait_out(60, lat, seen);
    y0 = out_data[15:0];
    y1 = out_data[31:16];
    st = out_sat;
    if (seen) take_out();
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; sel = '0; out_ready = 1'b0;
    coef_we = 1'b0; coef_set = '0; coef_idx = '0; coef_data = '0; flush = 1'b0;
    repeat (3) @(negedge clk_144);
    checks++;
    if ({in_ready, out_valid, busy, out_sat, out_data} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%0b vld=%0b busy=%0b sat=%0b data=%h want all 0",
               in_ready, out_valid, busy, out_sat, out_data);
    end
    reset_n = 1'b1;
    @(negedge clk_144);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release got rdy=%0b vld=%0b busy=%0b want 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_passthrough;
    logic signed [15:0] y0, y1; logic [1:0] st; int lat; bit seen;
    run_frame(3'd0, 16'sd1234, -16'sd32768, y0, y1, st, lat, seen);
    checks++;
    if (!seen || lat != 13) begin
      errors++;
      $display("FAIL pass_latency got seen=%0b lat=%0d want seen=1 lat=13", seen, lat);
    end
    checks++;
    if (y0 !== 16'sd1234 || y1 !== -16'sd32768 || st !== 2'b00) begin
      errors++;
      $display("FAIL pass_data got %0d %0d sat=%0b want 1234 -32768 sat=0", y0, y1, st);
    end
  endtask

  task automatic test_impulse;
    logic signed [15:0] y0, y1; logic [1:0] st; int lat; bit seen;
    logic signed [15:0] exp_y [3];
    // b0=b2=1/256, b1=1/128, a1=1.8125, a2=-0.828125 (stored negated):
    // y[0]=64, y[1]=2*64+1.8125*64=244, y[2]=64+1.8125*244-0.828125*64=453.25 -> 453
    exp_y[0] = 16'sd64; exp_y[1] = 16'sd244; exp_y[2] = 16'sd453;
    coef_write(3'd1, 3'd0, 32'd4194304);
    coef_write(3'd1, 3'd1, 32'd8388608);
    coef_write(3'd1, 3'd2, 32'd4194304);
    coef_write(3'd1, 3'd3, 32'd1946157056);
    coef_write(3'd1, 3'd4, -32'sd889192448);
    for (int i = 0; i < 3; i++) begin
      run_frame(3'd1, (i == 0) ? 16'sd16384 : 16'sd0, 16'sd0, y0, y1, st, lat, seen);
      checks++;
      if (!seen || y0 !== exp_y[i] || y1 !== 16'sd0) begin
        errors++;
        $display("FAIL impulse_%0d got seen=%0b ch0=%0d ch1=%0d want ch0=%0d ch1=0", i, seen, y0, y1, exp_y[i]);
      end
    end
  endtask

  task automatic test_set_switch;
    logic signed [15:0] y0, y1; logic [1:0] st; int lat; bit seen;
    run_frame(3'd0, 16'sd100, 16'sd0, y0, y1, st, lat, seen);
    checks++;
    if (!seen || y0 !== 16'sd100 || y1 !== 16'sd0) begin
      errors++;
      $display("FAIL set_switch got seen=%0b ch0=%0d ch1=%0d want 100 0", seen, y0, y1);
    end
  endtask

  task automatic test_saturation;
    logic signed [15:0] y0, y1; logic [1:0] st; int lat; bit seen;
    coef_write(3'd2, 3'd0, 32'h7FFF_FFFF);
    // ch1: (2^31-1)*100 >> 30 = 199 (no clip)
    run_frame(3'd2, 16'sd30000, 16'sd100, y0, y1, st, lat, seen);
    checks++;
    if (!seen || y0 !== 16'sd32767 || y1 !== 16'sd199 || st !== 2'b01) begin
      errors++;
      $display("FAIL sat_pos got seen=%0b ch0=%0d ch1=%0d sat=%b want 32767 199 01", seen, y0, y1, st);
    end
    // ch1: (2^31-1)*-100 >> 30 rounds toward -inf = -200
    run_frame(3'd2, -16'sd30000, -16'sd100, y0, y1, st, lat, seen);
    checks++;
    if (!seen || y0 !== -16'sd32768 || y1 !== -16'sd200 || st !== 2'b01) begin
      errors++;
      $display("FAIL sat_neg got seen=%0b ch0=%0d ch1=%0d sat=%b want -32768 -200 01", seen, y0, y1, st);
    end
  endtask

  task automatic test_back_to_back;
    logic signed [15:0] y0, y1; logic [1:0] st; int lat; bit seen;
    int bad = 0;
    coef_write(3'd3, 3'd0, 32'd536870912);      // b0 = 0.5
    start_frame(3'd3, 16'sd1000, 16'sd0);
    coef_write(3'd3, 3'd0, 32'd1073741824);     // b0 = 1.0 while the frame is in MAC
    wait_out(60, lat, seen);
    checks++;
    if (!seen || lat != 13 || out_data !== {16'sd0, 16'sd500}) begin
      errors++;
      $display("FAIL shadow_frame got seen=%0b lat=%0d data=%h want lat=13 data=%h",
               seen, lat, out_data, {16'sd0, 16'sd500});
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_144);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== {16'sd0, 16'sd500}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold got %0d bad cycles want 0", bad);
    end
    take_out();
    run_frame(3'd3, 16'sd1000, 16'sd0, y0, y1, st, lat, seen);
    checks++;
    if (!seen || y0 !== 16'sd1000) begin
      errors++;
      $display("FAIL shadow_next got seen=%0b ch0=%0d want 1000", seen, y0);
    end
  endtask

  task automatic test_flush;
    logic signed [15:0] y0, y1; logic [1:0] st; int lat; bit seen;
    start_frame(3'd3, 16'sd2000, 16'sd0);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_mid got busy=%0b rdy=%0b want 1 0", busy, in_ready);
    end
    repeat (4) @(negedge clk_144);
    flush = 1'b1;
    @(negedge clk_144);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_abort got busy=%0b rdy=%0b vld=%0b want 0 1 0", busy, in_ready, out_valid);
    end
    wait_out(40, lat, seen);
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_no_out got out_valid=1 at %0d want none", lat);
    end
    // flush together with an offered frame: the frame is dropped
    in_valid = 1'b1; in_data = {16'sd0, 16'sd7}; sel = 3'd0; flush = 1'b1;
    @(negedge clk_144);
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_vs_accept got busy=%0b rdy=%0b want 0 1", busy, in_ready);
    end
    run_frame(3'd0, 16'sd500, 16'sd0, y0, y1, st, lat, seen);
    checks++;
    if (!seen || y0 !== 16'sd500 || y1 !== 16'sd0) begin
      errors++;
      $display("FAIL flush_next got seen=%0b ch0=%0d ch1=%0d want 500 0", seen, y0, y1);
    end
  endtask

  task automatic test_reset_midframe;
    logic signed [15:0] y0, y1; logic [1:0] st; int lat; bit seen;
    start_frame(3'd2, 16'sd1000, 16'sd0);
    repeat (7) @(negedge clk_144);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, out_sat, out_data} !== 37'd0) begin
      errors++;
      $display("FAIL reset_mid got rdy=%0b vld=%0b busy=%0b sat=%0b data=%h want all 0",
               in_ready, out_valid, busy, out_sat, out_data);
    end
    @(negedge clk_144);
    reset_n = 1'b1;
    @(negedge clk_144);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready got %0b want 1", in_ready);
    end
    // set 2 held ~2.0 before reset; passthrough restored gives 1000, not 1999
    run_frame(3'd2, 16'sd1000, 16'sd0, y0, y1, st, lat, seen);
    checks++;
    if (!seen || y0 !== 16'sd1000 || st !== 2'b00) begin
      errors++;
      $display("FAIL reset_bank got seen=%0b ch0=%0d sat=%b want 1000 00", seen, y0, st);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_impulse();
    test_set_switch();
    test_saturation();
    test_back_to_back();
    test_flush();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
